// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: per-channel synchroniser, debounce filter
// and level/press/release/hold/auto-repeat event generation.
module debounce_multi #(
  parameter int   N           = 4,
  parameter int   CNT         = 100,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0,
  parameter int   HOLD_CNT    = 50000000,
  parameter int   REPEAT_CNT  = 10000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_in,
  output logic [N-1:0] o_level,
  output logic [N-1:0] o_press,
  output logic [N-1:0] o_release,
  output logic [N-1:0] o_hold,
  output logic [N-1:0] o_repeat
);

  localparam int CW   = $clog2(CNT + 1);
  localparam int HMAX = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CNT - 1);
  localparam logic [HW-1:0] REP_LAST  = (REPEAT_CNT > 0) ? HW'(REPEAT_CNT - 1) : '0;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic [HW-1:0]          r_hcnt;
    logic                   r_level;
    logic                   r_held;
    logic                   r_press;
    logic                   r_release;
    logic                   r_hold;
    logic                   r_repeat;
    logic                   w_s;
    logic                   w_level_nxt;

    assign w_s = r_sync[SYNC_STAGES-1];

    // The hold/repeat logic looks at the level being committed this edge, so a
    // release landing on a hold/repeat instant suppresses that pulse.
    assign w_level_nxt = (w_s != r_level && r_cnt == CNT_LAST) ? w_s : r_level;

    // NOTE: every state update below is non-blocking so all flops sample the
    // pre-edge values of each other, exactly like the hardware they describe.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync    <= {SYNC_STAGES{IDLE_LEVEL}};
        r_cnt     <= '0;
        r_hcnt    <= '0;
        r_level   <= IDLE_LEVEL;
        r_held    <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_hold    <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        r_sync    <= {r_sync[SYNC_STAGES-2:0], i_in[g]};
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_hold    <= 1'b0;
        r_repeat  <= 1'b0;

        if (w_s == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_level   <= w_s;
          r_cnt     <= '0;
          r_press   <= (w_s != IDLE_LEVEL);
          r_release <= (w_s == IDLE_LEVEL);
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end

        // The press edge itself is pressed cycle 1, so counting starts the
        // following edge.
        if (w_level_nxt == IDLE_LEVEL) begin
          r_hcnt <= '0;
          r_held <= 1'b0;
        end else if (r_level != IDLE_LEVEL) begin
          if (!r_held) begin
            if (r_hcnt == HOLD_LAST) begin
              r_hold   <= 1'b1;
              r_repeat <= 1'b1;
              r_held   <= 1'b1;
              r_hcnt   <= '0;
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end else if (REPEAT_CNT > 0) begin
            if (r_hcnt == REP_LAST) begin
              r_repeat <= 1'b1;
              r_hcnt   <= '0;
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
        end
      end
    end

    assign o_level[g]   = r_level;
    assign o_press[g]   = r_press;
    assign o_release[g] = r_release;
    assign o_hold[g]    = r_hold;
    assign o_repeat[g]  = r_repeat;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with N=2, CNT=4, SYNC_STAGES=2,
// HOLD_CNT=10, REPEAT_CNT=3; observed word is {level,press,release,hold,repeat}.
module tb_debounce_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] i_in = 2'b00;
  logic [1:0] o_level, o_press, o_release, o_hold, o_repeat;
  logic [9:0] w_obs;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] in;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  debounce_multi #(
    .N(2), .CNT(4), .SYNC_STAGES(2), .IDLE_LEVEL(1'b0),
    .HOLD_CNT(10), .REPEAT_CNT(3)
  ) dut (
    .clk(clk), .reset(reset), .i_in(i_in),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_hold(o_hold), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;

  assign w_obs = {o_level, o_press, o_release, o_hold, o_repeat};

  function automatic logic [9:0] pk(input logic [1:0] l, input logic [1:0] p,
                                    input logic [1:0] r, input logic [1:0] h,
                                    input logic [1:0] rp);
    return {l, p, r, h, rp};
  endfunction

  task automatic add(input logic [1:0] in, input logic [9:0] e);
    vec_t v;
    v.in  = in;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {lvl,prs,rel,hld,rep}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] in, input logic [9:0] exp, input string name);
    i_in = in;
    @(posedge clk);
    #1;
    check(name, w_obs, exp);
  endtask

  // Press channel mask m, drop the input before post-press edge hi_until,
  // and check every cycle through the release and two idle cycles after it.
  task automatic press_hold(input logic [1:0] m, input int hi_until, input string tag);
    logic [1:0] lvl, rel, hld, rep;
    for (int k = 1; k <= 5; k++) step(m, '0, $sformatf("%s_qual%0d", tag, k));
    step(m, pk(m, m, 2'b00, 2'b00, 2'b00), {tag, "_press"});
    for (int k = 1; k <= hi_until + 7; k++) begin
      lvl = (k < hi_until + 5) ? m : 2'b00;
      rel = (k == hi_until + 5) ? m : 2'b00;
      hld = (k == 10 && k < hi_until + 5) ? m : 2'b00;
      rep = (k >= 10 && (k - 10) % 3 == 0 && k < hi_until + 5) ? m : 2'b00;
      step((k < hi_until) ? m : 2'b00, pk(lvl, 2'b00, rel, hld, rep),
           $sformatf("%s_k%0d", tag, k));
    end
  endtask

  initial begin
    // Clean press/release and bounce on channel 0, starting from idle.
    for (int i = 0; i < 20; i++) add(2'b00, '0);
    for (int i = 0; i < 5; i++) add(2'b01, '0);
    add(2'b01, pk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    add(2'b01, pk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 5; i++) add(2'b00, pk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    add(2'b00, pk(2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    add(2'b00, '0);
    for (int i = 0; i < 3; i++) add(2'b01, '0);
    add(2'b00, '0);
    for (int i = 0; i < 5; i++) add(2'b01, '0);
    add(2'b01, pk(2'b01, 2'b01, 2'b00, 2'b00, 2'b00));
    add(2'b01, pk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 5; i++) add(2'b00, pk(2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    add(2'b00, pk(2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    add(2'b00, '0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", w_obs, '0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));

    // Reset asserted between edges with both inputs pressed.
    for (int k = 1; k <= 5; k++) step(2'b11, '0, $sformatf("both_qual%0d", k));
    step(2'b11, pk(2'b11, 2'b11, 2'b00, 2'b00, 2'b00), "both_press");
    step(2'b11, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00), "both_level");
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", w_obs, '0);
    for (int k = 1; k <= 3; k++) step(2'b11, '0, $sformatf("in_reset%0d", k));
    i_in  = 2'b00;
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) step(2'b00, '0, $sformatf("post_reset_idle%0d", k));

    // Reset mid-qualification (cnt=2) must force a full fresh qualification.
    for (int k = 1; k <= 4; k++) step(2'b11, '0, $sformatf("mid_qual%0d", k));
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset", w_obs, '0);
    step(2'b11, '0, "mid_in_reset");
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) step(2'b11, '0, $sformatf("requal%0d", k));
    step(2'b11, pk(2'b11, 2'b11, 2'b00, 2'b00, 2'b00), "requal_press");
    step(2'b11, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00), "requal_level");
    for (int k = 1; k <= 5; k++)
      step(2'b00, pk(2'b11, 2'b00, 2'b00, 2'b00, 2'b00), $sformatf("both_rel%0d", k));
    step(2'b00, pk(2'b00, 2'b00, 2'b11, 2'b00, 2'b00), "both_release");
    step(2'b00, '0, "both_idle");

    // Long press with release landing on a would-be repeat instant.
    press_hold(2'b10, 17, "long");
    // Release landing exactly on the would-be hold instant, then a re-press.
    press_hold(2'b10, 5, "early");
    press_hold(2'b10, 12, "repress");
    press_hold(2'b01, 12, "ch0hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
